// File: rtl/bp_nonsynth_stall_histogram_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_nonsynth_stall_histogram_if
// Brief    : Read bus of the stall histogram: request/address in, valid/data out.
// Revision : 1.0
// ============================================================================
interface bp_nonsynth_stall_histogram_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic                  rd_v_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  rd_v_o;
    logic [DATA_WIDTH-1:0] rd_data_o;

    modport master (output rd_v_i, output rd_addr_i, input  rd_v_o, input  rd_data_o);
    modport slave  (input  rd_v_i, input  rd_addr_i, output rd_v_o, output rd_data_o);
endinterface
`default_nettype wire

// File: rtl/bp_nonsynth_stall_histogram.sv
`default_nettype none
// ============================================================================
// Module   : bp_nonsynth_stall_histogram
// Brief    : Per-channel stall-reason / instret / cycle profiling counters with
//            a registered read port. Define BP_STALL_HIST_SATURATE_EN for
//            saturating counters (default: wrapping).
// Revision : 1.0
// ============================================================================
module bp_nonsynth_stall_histogram #(
    parameter int num_chan_p    = 1,
    parameter int num_reasons_p = 32,
    parameter int cntr_width_p  = 32
) (
    input  wire logic                              clk_i,
    input  wire logic                              aresetn_i,
    input  wire logic                              en_i,
    input  wire logic                              clear_i,
    input  wire logic [num_chan_p-1:0]             sample_v_i,
    input  wire logic [num_chan_p-1:0]             instret_i,
    input  wire logic [num_chan_p*num_reasons_p-1:0] stall_vec_i,
    bp_nonsynth_stall_histogram_if.slave           rd,
    output logic [num_chan_p-1:0]                  overflow_o
);
    localparam int entries_lp    = num_reasons_p + 3;
    localparam int c_chan_w      = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam int c_entry_w     = (entries_lp > 1) ? $clog2(entries_lp) : 1;
    localparam int addr_width_lp = c_chan_w + c_entry_w;
    localparam int c_reason_w    = (num_reasons_p > 1) ? $clog2(num_reasons_p) : 1;
    localparam int c_unknown     = num_reasons_p;
    localparam int c_instret     = num_reasons_p + 1;
    localparam int c_cycles      = num_reasons_p + 2;

    logic [num_chan_p-1:0]   r_s0_v;
    logic [num_chan_p-1:0]   r_s0_instret;
    logic [num_chan_p-1:0]   r_s0_any;
    logic [c_reason_w-1:0]   r_s0_idx  [num_chan_p];
    logic [c_reason_w-1:0]   w_enc_idx [num_chan_p];
    logic [num_chan_p-1:0]   w_any;
    logic [entries_lp-1:0]   w_inc     [num_chan_p];
    logic [cntr_width_p-1:0] r_cnt     [num_chan_p][entries_lp];
    logic [num_chan_p-1:0]   r_ovf;
    logic [addr_width_lp-1:0] w_rd_addr;
    logic [c_chan_w-1:0]     w_rd_chan;
    logic [c_entry_w-1:0]    w_rd_entry;
    logic [cntr_width_p-1:0] w_rd_data;
    logic                    r_rd_v;
    logic [cntr_width_p-1:0] r_rd_data;

    // Descending scan so the lowest set bit is the last (winning) assignment.
    always_comb begin
        for (int c = 0; c < num_chan_p; c++) begin
            w_enc_idx[c] = '0;
            w_any[c]     = |stall_vec_i[c*num_reasons_p +: num_reasons_p];
            for (int i = num_reasons_p - 1; i >= 0; i--) begin
                if (stall_vec_i[c*num_reasons_p + i]) begin
                    w_enc_idx[c] = c_reason_w'(i);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_s0_v       <= '0;
            r_s0_instret <= '0;
            r_s0_any     <= '0;
            for (int c = 0; c < num_chan_p; c++) r_s0_idx[c] <= '0;
        end else if (clear_i) begin
            r_s0_v       <= '0;
            r_s0_instret <= '0;
            r_s0_any     <= '0;
            for (int c = 0; c < num_chan_p; c++) r_s0_idx[c] <= '0;
        end else begin
            r_s0_v <= en_i ? sample_v_i : '0;
            for (int c = 0; c < num_chan_p; c++) begin
                if (en_i && sample_v_i[c]) begin
                    r_s0_instret[c] <= instret_i[c];
                    r_s0_any[c]     <= w_any[c];
                    r_s0_idx[c]     <= w_enc_idx[c];
                end
            end
        end
    end

    // One-hot-plus-cycle increment mask per channel for the S1 update.
    always_comb begin
        for (int c = 0; c < num_chan_p; c++) begin
            w_inc[c] = '0;
            if (r_s0_v[c]) begin
                w_inc[c][c_cycles] = 1'b1;
                if (r_s0_instret[c]) begin
                    w_inc[c][c_instret] = 1'b1;
                end else if (r_s0_any[c]) begin
                    for (int e = 0; e < num_reasons_p; e++) begin
                        if (int'(r_s0_idx[c]) == e) w_inc[c][e] = 1'b1;
                    end
                end else begin
                    w_inc[c][c_unknown] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_ovf <= '0;
            for (int c = 0; c < num_chan_p; c++)
                for (int e = 0; e < entries_lp; e++) r_cnt[c][e] <= '0;
        end else if (clear_i) begin
            r_ovf <= '0;
            for (int c = 0; c < num_chan_p; c++)
                for (int e = 0; e < entries_lp; e++) r_cnt[c][e] <= '0;
        end else begin
            for (int c = 0; c < num_chan_p; c++) begin
                for (int e = 0; e < entries_lp; e++) begin
                    if (w_inc[c][e]) begin
                        if (&r_cnt[c][e]) begin
                            r_ovf[c] <= 1'b1;
`ifdef BP_STALL_HIST_SATURATE_EN
                            r_cnt[c][e] <= r_cnt[c][e];
`else
                            r_cnt[c][e] <= '0;
`endif
                        end else begin
                            r_cnt[c][e] <= r_cnt[c][e] + cntr_width_p'(1);
                        end
                    end
                end
            end
        end
    end

    assign w_rd_addr  = rd.rd_addr_i;
    assign w_rd_chan  = w_rd_addr[addr_width_lp-1 -: c_chan_w];
    assign w_rd_entry = w_rd_addr[c_entry_w-1:0];

    // Unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        w_rd_data = '0;
        for (int c = 0; c < num_chan_p; c++)
            for (int e = 0; e < entries_lp; e++)
                if (int'(w_rd_chan) == c && int'(w_rd_entry) == e) w_rd_data = r_cnt[c][e];
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_rd_v    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_v <= rd.rd_v_i;
            if (rd.rd_v_i) r_rd_data <= w_rd_data;
        end
    end

    assign rd.rd_v_o    = r_rd_v;
    assign rd.rd_data_o = r_rd_data;
    assign overflow_o   = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_bp_nonsynth_stall_histogram.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_nonsynth_stall_histogram
// Brief    : Self-checking bench: directed scenarios plus random traffic against
//            a counting model. Honours BP_STALL_HIST_SATURATE_EN.
// Revision : 1.0
// ============================================================================
module tb_bp_nonsynth_stall_histogram;
    localparam int NCH = 2;
    localparam int NR  = 8;
    localparam int CW  = 8;
    localparam int NE  = NR + 3;
    localparam int AW  = 1 + 4;

    logic             clk_i = 1'b0;
    logic             aresetn_i;
    logic             en_i;
    logic             clear_i;
    logic [NCH-1:0]   sample_v_i;
    logic [NCH-1:0]   instret_i;
    logic [NCH*NR-1:0] stall_vec_i;
    logic [NCH-1:0]   overflow_o;

    int checks = 0;
    int errors = 0;

    // Model: counts per channel/entry plus a one-deep pending sample per channel.
    int unsigned m_cnt [NCH][NE];
    bit [NCH-1:0] m_ovf;
    bit           p_v  [NCH];
    int           p_e  [NCH];

    bp_nonsynth_stall_histogram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(CW)) rd_if();

    bp_nonsynth_stall_histogram #(
        .num_chan_p   (NCH),
        .num_reasons_p(NR),
        .cntr_width_p (CW)
    ) dut (
        .clk_i      (clk_i),
        .aresetn_i  (aresetn_i),
        .en_i       (en_i),
        .clear_i    (clear_i),
        .sample_v_i (sample_v_i),
        .instret_i  (instret_i),
        .stall_vec_i(stall_vec_i),
        .rd         (rd_if),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int target(input bit ins, input logic [NR-1:0] vec);
        if (ins) return NR + 1;
        for (int i = 0; i < NR; i++) if (vec[i]) return i;
        return NR;
    endfunction

    task automatic m_bump(input int c, input int e);
        if (m_cnt[c][e] == (1 << CW) - 1) begin
            m_ovf[c] = 1'b1;
`ifndef BP_STALL_HIST_SATURATE_EN
            m_cnt[c][e] = 0;
`endif
        end else begin
            m_cnt[c][e]++;
        end
    endtask

    task automatic m_zero();
        for (int c = 0; c < NCH; c++) begin
            for (int e = 0; e < NE; e++) m_cnt[c][e] = 0;
            p_v[c] = 1'b0;
        end
        m_ovf = '0;
    endtask

    // Advance one clock, updating the model with what that edge should do.
    task automatic tick();
        if (clear_i) begin
            m_zero();
        end else begin
            for (int c = 0; c < NCH; c++)
                if (p_v[c]) begin
                    m_bump(c, p_e[c]);
                    m_bump(c, NE - 1);
                end
            for (int c = 0; c < NCH; c++) begin
                p_v[c] = en_i && sample_v_i[c];
                p_e[c] = target(instret_i[c], stall_vec_i[c*NR +: NR]);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        en_i = 1'b1; clear_i = 1'b0; sample_v_i = '0; instret_i = '0; stall_vec_i = '0;
    endtask

    task automatic do_read(input int c, input int e, output logic [CW-1:0] d, output logic v);
        rd_if.rd_v_i    = 1'b1;
        rd_if.rd_addr_i = AW'((c << 4) | e);
        tick();
        rd_if.rd_v_i = 1'b0;
        d = rd_if.rd_data_o;
        v = rd_if.rd_v_o;
    endtask

    task automatic do_clear();
        clear_i = 1'b1; tick(); clear_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [CW-1:0] d; logic v;
        aresetn_i = 1'b0; idle(); rd_if.rd_v_i = 1'b0; rd_if.rd_addr_i = '0;
        m_zero();
        #2;
        checks++; if (rd_if.rd_v_o !== 1'b0) begin errors++; $display("FAIL reset_rd_v got %b exp 0", rd_if.rd_v_o); end
        checks++; if (rd_if.rd_data_o !== '0) begin errors++; $display("FAIL reset_rd_data got %0d exp 0", rd_if.rd_data_o); end
        checks++; if (overflow_o !== '0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow_o); end
        @(negedge clk_i); aresetn_i = 1'b1;
        tick();
        for (int c = 0; c < NCH; c++)
            for (int e = 0; e < NE; e++) begin
                do_read(c, e, d, v);
                checks++;
                if (v !== 1'b1 || d !== '0) begin errors++; $display("FAIL reset_read c%0d e%0d got v=%b d=%0d exp v=1 d=0", c, e, v, d); end
            end
        tick();
        checks++; if (rd_if.rd_v_o !== 1'b0) begin errors++; $display("FAIL rd_v_single_cycle got %b exp 0", rd_if.rd_v_o); end
    endtask

    task automatic test_directed();
        logic [CW-1:0] d; logic v;
        do_clear();
        sample_v_i = 2'b11; instret_i = 2'b10; stall_vec_i = {8'hFF, 8'b0010_0100};
        for (int i = 0; i < 10; i++) begin
            if (i == 5) sample_v_i[1] = 1'b0;
            tick();
        end
        idle(); tick(); tick();
        do_read(0, 2, d, v);  checks++; if (d !== 8'd10) begin errors++; $display("FAIL dir_ch0_e2 got %0d exp 10", d); end
        do_read(0, 5, d, v);  checks++; if (d !== 8'd0)  begin errors++; $display("FAIL dir_ch0_e5 got %0d exp 0", d); end
        do_read(0, 10, d, v); checks++; if (d !== 8'd10) begin errors++; $display("FAIL dir_ch0_cycles got %0d exp 10", d); end
        do_read(1, 9, d, v);  checks++; if (d !== 8'd5)  begin errors++; $display("FAIL dir_ch1_instret got %0d exp 5", d); end
        for (int e = 0; e <= NR; e++) begin
            do_read(1, e, d, v); checks++;
            if (d !== 8'd0) begin errors++; $display("FAIL dir_ch1_e%0d got %0d exp 0", e, d); end
        end
        sample_v_i = 2'b01; instret_i = 2'b00; stall_vec_i = '0;
        repeat (3) tick();
        idle(); tick(); tick();
        do_read(0, 8, d, v); checks++; if (d !== 8'd3) begin errors++; $display("FAIL dir_ch0_unknown got %0d exp 3", d); end
    endtask

    task automatic test_read_collision();
        logic [CW-1:0] d; logic v;
        do_clear();
        sample_v_i = 2'b01; stall_vec_i = 16'h0001;
        repeat (8) tick();
        idle();
        do_read(0, 0, d, v);
        checks++; if (v !== 1'b1 || d !== 8'd7) begin errors++; $display("FAIL collide_pre got v=%b d=%0d exp v=1 d=7", v, d); end
        do_read(0, 0, d, v);
        checks++; if (v !== 1'b1 || d !== 8'd8) begin errors++; $display("FAIL collide_post got v=%b d=%0d exp v=1 d=8", v, d); end
    endtask

    task automatic test_clear();
        logic [CW-1:0] d; logic v; int unsigned exp_pre;
        sample_v_i = 2'b01; stall_vec_i = 16'h0008;
        repeat (4) tick();
        idle(); tick(); tick();
        exp_pre = m_cnt[0][NE-1];
        clear_i = 1'b1;
        do_read(0, NE - 1, d, v);
        clear_i = 1'b0;
        checks++; if (d !== CW'(exp_pre)) begin errors++; $display("FAIL clear_coincident_read got %0d exp %0d", d, exp_pre); end
        do_read(0, NE - 1, d, v);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL clear_zeroed got %0d exp 0", d); end
        sample_v_i = 2'b10; stall_vec_i = 16'h0200;
        tick();
        idle(); clear_i = 1'b1; tick(); clear_i = 1'b0; tick(); tick();
        do_read(1, 1, d, v);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL clear_discard_s0 got %0d exp 0", d); end
    endtask

    task automatic test_enable();
        logic [CW-1:0] d; logic v;
        do_clear();
        en_i = 1'b0; sample_v_i = 2'b11; stall_vec_i = 16'h0101;
        repeat (5) tick();
        en_i = 1'b1; tick();
        en_i = 1'b0; repeat (3) tick();
        idle(); tick(); tick();
        do_read(0, NE - 1, d, v); checks++; if (d !== 8'd1) begin errors++; $display("FAIL enable_ch0_cycles got %0d exp 1", d); end
        do_read(1, 0, d, v);      checks++; if (d !== 8'd1) begin errors++; $display("FAIL enable_ch1_e0 got %0d exp 1", d); end
    endtask

    task automatic test_random();
        logic [CW-1:0] d; logic v;
        do_clear();
        for (int i = 0; i < 400; i++) begin
            en_i    = ($urandom_range(0, 7) != 0);
            clear_i = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < NCH; c++) begin
                sample_v_i[c] = ($urandom_range(0, 3) != 0);
                instret_i[c]  = ($urandom_range(0, 2) == 0);
                stall_vec_i[c*NR +: NR] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            tick();
        end
        idle(); tick(); tick();
        for (int c = 0; c < NCH; c++)
            for (int e = 0; e < NE; e++) begin
                do_read(c, e, d, v); checks++;
                if (v !== 1'b1 || d !== CW'(m_cnt[c][e])) begin
                    errors++; $display("FAIL rand_c%0d_e%0d got v=%b d=%0d exp v=1 d=%0d", c, e, v, d, m_cnt[c][e]);
                end
            end
        checks++; if (overflow_o !== m_ovf) begin errors++; $display("FAIL rand_ovf got %b exp %b", overflow_o, m_ovf); end
    endtask

    task automatic test_overflow();
        logic [CW-1:0] d; logic v;
        do_clear();
        sample_v_i = 2'b01; stall_vec_i = 16'h0001;
        repeat (300) tick();
        idle(); tick(); tick();
        do_read(0, 0, d, v);
`ifdef BP_STALL_HIST_SATURATE_EN
        checks++; if (d !== 8'd255) begin errors++; $display("FAIL ovf_entry0 got %0d exp 255", d); end
`else
        checks++; if (d !== 8'd44) begin errors++; $display("FAIL ovf_entry0 got %0d exp 44", d); end
`endif
        checks++; if (overflow_o !== 2'b01) begin errors++; $display("FAIL ovf_flag got %b exp 01", overflow_o); end
        do_read(0, 11, d, v);
        checks++; if (v !== 1'b1 || d !== 8'd0) begin errors++; $display("FAIL oor_e11 got v=%b d=%0d exp v=1 d=0", v, d); end
        do_read(1, 15, d, v);
        checks++; if (v !== 1'b1 || d !== 8'd0) begin errors++; $display("FAIL oor_e15 got v=%b d=%0d exp v=1 d=0", v, d); end
        do_clear();
        do_read(0, 0, d, v);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL ovf_clear_entry0 got %0d exp 0", d); end
        checks++; if (overflow_o !== 2'b00) begin errors++; $display("FAIL ovf_clear_flag got %b exp 00", overflow_o); end
    endtask

    task automatic test_reset_mid();
        logic [CW-1:0] d; logic v;
        do_clear();
        sample_v_i = 2'b11; stall_vec_i = {8'h08, 8'h04};
        repeat (260) tick();
        checks++; if (overflow_o !== 2'b11) begin errors++; $display("FAIL pre_reset_ovf got %b exp 11", overflow_o); end
        rd_if.rd_v_i = 1'b1; rd_if.rd_addr_i = AW'(2);
        #2 aresetn_i = 1'b0;
        #1;
        checks++; if (overflow_o !== 2'b00) begin errors++; $display("FAIL midreset_ovf got %b exp 00", overflow_o); end
        checks++; if (rd_if.rd_v_o !== 1'b0 || rd_if.rd_data_o !== '0) begin
            errors++; $display("FAIL midreset_rd got v=%b d=%0d exp v=0 d=0", rd_if.rd_v_o, rd_if.rd_data_o);
        end
        @(posedge clk_i); #1;
        rd_if.rd_v_i = 1'b0;
        checks++; if (rd_if.rd_v_o !== 1'b0) begin errors++; $display("FAIL midreset_hold_rd_v got %b exp 0", rd_if.rd_v_o); end
        @(negedge clk_i); aresetn_i = 1'b1;
        m_zero();
        sample_v_i = 2'b01; stall_vec_i = 16'h0004;
        repeat (5) tick();
        idle(); tick(); tick();
        do_read(0, 2, d, v);      checks++; if (d !== 8'd5) begin errors++; $display("FAIL resume_e2 got %0d exp 5", d); end
        do_read(0, NE - 1, d, v); checks++; if (d !== 8'd5) begin errors++; $display("FAIL resume_cycles got %0d exp 5", d); end
        do_read(1, 3, d, v);      checks++; if (d !== 8'd0) begin errors++; $display("FAIL resume_ch1 got %0d exp 0", d); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_read_collision();
        test_clear();
        test_enable();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
